// File: rtl/nv_ram_pkg.sv
// Shared types for the self-clearing 1R1W RAM.
// State encoding and read-collision mode selectors.
package nv_ram_pkg;

  typedef enum logic {
    INIT,
    READY
  } nv_ram_state_t;

  localparam int RD_WRITE_FIRST = 0;
  localparam int RD_READ_FIRST  = 1;

endpackage

// File: rtl/nv_ram_init_seq.sv
// Post-reset self-clear sequencer: walks every entry once,
// then parks in READY until the next reset.
module nv_ram_init_seq
  import nv_ram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_done
);

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  nv_ram_state_t state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_we   = (state_q == INIT);
  assign init_addr = cnt_q[AW-1:0];
  assign init_done = (state_q == READY);

endmodule

// File: rtl/nv_ram_rwsp_init.sv
// Parametrised 1R1W RAM with post-reset self-clear, selectable
// read-collision behaviour and a sticky out-of-range flag.
module nv_ram_rwsp_init
  import nv_ram_pkg::*;
#(
  parameter int          DW       = 11,
  parameter int          AW       = 8,
  parameter int          DEPTH    = 256,
  parameter int          RD_MODE  = RD_WRITE_FIRST,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_done,
  output logic          addr_err
);

  if (DEPTH > 2**AW || DEPTH < 2) begin : g_bad_depth
    $fatal(1, "nv_ram_rwsp_init: DEPTH out of range");
  end

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  logic          init_we;
  logic [AW-1:0] init_addr;

  nv_ram_init_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          ra_ok, wa_ok;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] rdata;

  assign ra_ok = {1'b0, ra} < DEPTH_W;
  assign wa_ok = {1'b0, wa} < DEPTH_W;

  // The init walk owns the write port until READY.
  always_comb begin
    mem_we = init_we;
    mem_wa = init_addr;
    mem_wd = INIT_VAL;
    if (init_done) begin
      mem_we = we && wa_ok;
      mem_wa = wa;
      mem_wd = di;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  if (RD_MODE == RD_READ_FIRST) begin : g_rf
    logic [DW-1:0] rd_q, rd_d;

    always_comb begin
      rd_d = rd_q;
      if (init_done && re) rd_d = ra_ok ? mem[ra] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign rdata = rd_q;
  end else begin : g_wf
    logic [AW-1:0] ra_q, ra_d;
    logic          ok_q, ok_d;

    always_comb begin
      ra_d = ra_q;
      ok_d = ok_q;
      if (init_done && re) begin
        ra_d = ra;
        ok_d = ra_ok;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ra_q <= '0;
        ok_q <= 1'b0;
      end else begin
        ra_q <= ra_d;
        ok_q <= ok_d;
      end
    end

    // Address held, array read late: same-cycle writes show through.
    assign rdata = ok_q ? mem[ra_q] : '0;
  end

  logic [DW-1:0] dout_q, dout_d;
  logic          addr_err_q, addr_err_d;

  always_comb begin
    dout_d     = dout_q;
    addr_err_d = addr_err_q;
    if (init_done) begin
      if (ore) dout_d = rdata;
      if ((re && !ra_ok) || (we && !wa_ok)) addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign dout     = dout_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_nv_ram_rwsp_init.sv
// Bench for nv_ram_rwsp_init: write-first full-depth instance and
// read-first DEPTH=200 instance driven by shared stimulus.
module tb_nv_ram_rwsp_init;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ra, wa;
  logic        re, ore, we;
  logic [10:0] di;
  logic [31:0] pwr;
  logic [10:0] dout0, dout1;
  logic        done0, done1, ae0, ae1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nv_ram_rwsp_init #(
    .DW(11), .AW(8), .DEPTH(256), .RD_MODE(0), .INIT_VAL(11'h155)
  ) u0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout0),
    .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwr),
    .init_done(done0), .addr_err(ae0)
  );

  nv_ram_rwsp_init #(
    .DW(11), .AW(8), .DEPTH(200), .RD_MODE(1), .INIT_VAL(11'h155)
  ) u1 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout1),
    .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwr),
    .init_done(done1), .addr_err(ae1)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [10:0] di;
    logic        re;
    logic [7:0]  ra;
    logic        ore;
    logic [10:0] e0;
    logic [10:0] e1;
    logic        ae1;
  } vec_t;

  typedef struct {
    logic [10:0] e0;
    logic [10:0] e1;
    logic        ae1;
    int          idx;
  } exp_t;

  vec_t tbl [24];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] a,
                       input logic [10:0] d, input logic r,
                       input logic [7:0] b, input logic o);
    we = w; wa = a; di = d; re = r; ra = b; ore = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic w, input logic [7:0] a,
                             input logic [10:0] d, input logic r,
                             input logic [7:0] b, input logic o,
                             input logic [10:0] e0, input logic [10:0] e1,
                             input logic x1);
    vec_t t;
    t.we = w; t.wa = a; t.di = d; t.re = r; t.ra = b; t.ore = o;
    t.e0 = e0; t.e1 = e1; t.ae1 = x1;
    return t;
  endfunction

  // Counts edges from now until each init_done rises; 0 = timeout.
  task automatic wait_init(input logic busy, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int c = 1; c <= 1000 && (c0 == 0 || c1 == 0); c++) begin
      if (busy && c <= 150) drive(1, 8'h30, 11'h3FF, 1, 8'hF5, 1);
      else                  drive(0, 0, 0, 0, 0, 0);
      tick();
      if (done0 && c0 == 0) c0 = c;
      if (done1 && c1 == 0) c1 = c;
      if (busy && c <= 150 && c1 == 0) begin
        chk("init_dout0", 32'(dout0), 0);
        chk("init_dout1", 32'(dout1), 0);
        chk("init_ae1", 32'(ae1), 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int c0, c1;
    exp_t e;

    tbl[0]  = v(1, 8'h10, 11'h3AB, 0, 8'h00, 0, 11'h155, 11'h155, 0);
    tbl[1]  = v(0, 8'h00, 11'h000, 1, 8'h10, 0, 11'h155, 11'h155, 0);
    tbl[2]  = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h3AB, 11'h3AB, 0);
    tbl[3]  = v(1, 8'h20, 11'h001, 0, 8'h00, 0, 11'h3AB, 11'h3AB, 0);
    tbl[4]  = v(1, 8'h20, 11'h7FF, 1, 8'h20, 0, 11'h3AB, 11'h3AB, 0);
    tbl[5]  = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h7FF, 11'h001, 0);
    tbl[6]  = v(0, 8'h00, 11'h000, 1, 8'h05, 1, 11'h7FF, 11'h001, 0);
    tbl[7]  = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h155, 11'h155, 0);
    tbl[8]  = v(1, 8'h05, 11'h0AA, 0, 8'h00, 0, 11'h155, 11'h155, 0);
    tbl[9]  = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h0AA, 11'h155, 0);
    tbl[10] = v(0, 8'h00, 11'h000, 1, 8'h10, 0, 11'h0AA, 11'h155, 0);
    tbl[11] = v(1, 8'h10, 11'h011, 0, 8'h00, 0, 11'h0AA, 11'h155, 0);
    tbl[12] = v(0, 8'h00, 11'h000, 0, 8'h00, 0, 11'h0AA, 11'h155, 0);
    tbl[13] = v(0, 8'h00, 11'h000, 0, 8'h00, 0, 11'h0AA, 11'h155, 0);
    tbl[14] = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h011, 11'h3AB, 0);
    tbl[15] = v(0, 8'h00, 11'h000, 1, 8'hF0, 0, 11'h011, 11'h3AB, 1);
    tbl[16] = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h155, 11'h000, 1);
    tbl[17] = v(1, 8'hC8, 11'h123, 0, 8'h00, 0, 11'h155, 11'h000, 1);
    tbl[18] = v(0, 8'h00, 11'h000, 1, 8'hC7, 0, 11'h155, 11'h000, 1);
    tbl[19] = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h155, 11'h155, 1);
    tbl[20] = v(0, 8'h00, 11'h000, 1, 8'h00, 1, 11'h155, 11'h155, 1);
    tbl[21] = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h155, 11'h155, 1);
    tbl[22] = v(0, 8'h00, 11'h000, 1, 8'hC8, 0, 11'h155, 11'h155, 1);
    tbl[23] = v(0, 8'h00, 11'h000, 0, 8'h00, 1, 11'h123, 11'h000, 1);

    rst = 1'b1;
    pwr = 32'hDEAD_BEEF;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_dout0", 32'(dout0), 0);
    chk("rst_dout1", 32'(dout1), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_ae0", 32'(ae0), 0);
    chk("rst_ae1", 32'(ae1), 0);

    rst = 1'b0;
    wait_init(1'b1, c0, c1);
    chk("init_len0", 32'(c0), 256);
    chk("init_len1", 32'(c1), 200);

    for (int i = 0; i <= 200; i++) begin
      drive(0, 0, 0, i < 200, 8'(i), i > 0);
      tick();
      if (i > 0) begin
        chk($sformatf("sweep0_%0h", i - 1), 32'(dout0), 32'h155);
        chk($sformatf("sweep1_%0h", i - 1), 32'(dout1), 32'h155);
      end
    end
    chk("sweep_ae1", 32'(ae1), 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].di,
            tbl[i].re, tbl[i].ra, tbl[i].ore);
      sb.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].ae1, i});
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_dout0", e.idx), 32'(dout0), 32'(e.e0));
      chk($sformatf("vec%0d_dout1", e.idx), 32'(dout1), 32'(e.e1));
      chk($sformatf("vec%0d_ae0", e.idx), 32'(ae0), 0);
      chk($sformatf("vec%0d_ae1", e.idx), 32'(ae1), 32'(e.ae1));
    end
    drive(0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    #1;
    chk("arst_dout0", 32'(dout0), 0);
    chk("arst_ae1", 32'(ae1), 0);
    chk("arst_done0", 32'(done0), 0);
    tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("mid_done0", 32'(done0), 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("pulse_done1", 32'(done1), 0);
    wait_init(1'b0, c0, c1);
    chk("reinit_len0", 32'(c0), 256);
    chk("reinit_len1", 32'(c1), 200);

    drive(0, 0, 0, 1, 8'h10, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("reclr_dout0", 32'(dout0), 32'h155);
    chk("reclr_dout1", 32'(dout1), 32'h155);
    drive(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
